tqvp_fpu_bus_initiator: RTL and testbench
=========================================

// Module: tqvp_fpu_bus_initiator
// PURPOSE
//  Bus initiator (host side) for the TinyQV memory-mapped FPU peripheral. Accepts one
//  command {op, a, b} on a valid/ready port and performs the peripheral bus sequence:
//  write A, write B, wait for data_ready, read result. Returns the result on a
//  valid/ready response port. Used as a coprocessor front-end and as a bus driver in
//  the FPU test harness.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles before the command is aborted with rsp_err=1 (>=2)
//  RESULT_ADDR     6'h0C  peripheral address of the result register
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   async active-low reset
//  cmd_valid      in   1   command present
//  cmd_ready      out  1   command accepted when cmd_valid&&cmd_ready
//  cmd_op         in   3   0 ADD, 1 SUB, 2 MULT, 3-7 issued but never complete (timeout)
//  cmd_a          in   32  operand A (fp16 in [15:0])
//  cmd_b          in   32  operand B (fp16 in [15:0])
//  rsp_valid      out  1   response held until rsp_ready
//  rsp_ready      in   1   response consumer ready
//  rsp_result     out  32  result word read from the peripheral
//  rsp_err        out  1   1 = timeout, rsp_result = 0
//  busy           out  1   state != IDLE
//  op_count       out  16  completed commands (ok or err), wraps 0xFFFF->0
//  bus_address    out  6   peripheral address
//  bus_data_out   out  32  write data to the peripheral
//  bus_write_n    out  2   2'b10 = 32-bit write strobe, 2'b11 = none
//  bus_read_n     out  2   2'b10 = 32-bit read strobe, 2'b11 = none
//  bus_data_in    in   32  read data from the peripheral, combinational in the same cycle
//  bus_data_ready in   1   peripheral result-ready flag
// BEHAVIOUR
//  Reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0,
//    op_count=0, bus_address=0, bus_data_out=0, bus_write_n=2'b11, bus_read_n=2'b11.
//  All bus_* outputs are registered. Each strobe is active for exactly one cycle.
//  FSM:
//   IDLE:   cmd_ready=1. On handshake, latch op/a/b and go to WR_A.
//   WR_A:   address={1'b0,op,2'b00}, data=a, write_n=10. Go to WR_B.
//   WR_B:   address={1'b0,op,2'b01}, data=b, write_n=10. Clear the timer. Go to WAIT.
//   WAIT:   sample bus_data_ready. If 1, go to RD. Otherwise increment the timer.
//           When timer==TIMEOUT_CYCLES-1: rsp_err=1, rsp_result=0, go to RESP.
//   RD:     address=RESULT_ADDR, read_n=10. Capture bus_data_in into rsp_result
//           in this cycle. Go to RESP.
//   RESP:   rsp_valid=1. On rsp_ready: op_count++, rsp_valid=0, rsp_err=0, go to IDLE.
//  Stale data_ready from a previous command is safe: the peripheral clears it on the
//    A write, so ready is low by the first WAIT sample.
//  Latency: handshake at cycle T; A strobe T+1; B strobe T+2; first WAIT sample T+3;
//    RD one cycle after data_ready is seen high; rsp_valid the cycle after RD.
//  cmd_ready=0 outside IDLE. Commands presented while busy are not consumed.
//  rsp_ready held high in RESP: response is consumed in 1 cycle, cmd_ready rises the
//    next cycle. There is no same-cycle response->command turnaround.
//  After a timeout the peripheral can stay in its calculating state. The next command
//    is still issued as normal; recovery is a system reset.
//  Reset mid-operation: every register and strobe returns to its reset value
//    asynchronously. No partial strobe is emitted after reset release.
//  op_count wraps modulo 2^16 with no saturation.
// TESTING
//  1 ADD a=0x3C00 b=0x4000; model ready 3 cycles after B -> rsp_result=0x00004200,
//    err=0; strobes at addresses 0x00, 0x01, 0x0C in order.
//  2 SUB a=0x4200 b=0x3C00 -> addresses 0x04/0x05 written, rsp_result=0x00004000.
//  3 MULT a=0x4000 b=0x4200 -> addresses 0x08/0x09, rsp_result=0x00004600,
//    op_count=1 after 1 cmd.
//  4 op=3 with model never ready -> rsp_valid exactly TIMEOUT_CYCLES WAIT cycles
//    after B strobe, err=1, result=0, no read strobe.
//  5 rsp_ready low 10 cycles -> rsp_valid/result stable, cmd_ready=0, second cmd_valid
//    not accepted until 1 cycle after rsp_ready.
//  6 assert rst_n=0 during WAIT -> all outputs reset values immediately; the next
//    command after release completes normally (0x3C00+0x3C00 -> 0x4000).

Source files
------------

// File: rtl/tqvp_fpu_bus_initiator.sv
// Host-side bus initiator for the TinyQV FPU peripheral: takes one {op, a, b} command,
// writes A and B, polls data_ready with a bounded wait, reads the result and returns it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | cmd_ready high, waiting for a command handshake
// S_WR_A  | A write strobe on the bus, B write being set up
// S_WR_B  | B write strobe on the bus, wait timer being loaded
// S_WAIT  | polling bus_data_ready, timer counting down to the abort point
// S_RD    | result read strobe on the bus, bus_data_in captured this cycle
// S_RESP  | rsp_valid held until rsp_ready
module tqvp_fpu_bus_initiator #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [5:0] RESULT_ADDR    = 6'h0C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] op_count,
    output logic [5:0]  bus_address,
    output logic [31:0] bus_data_out,
    output logic [1:0]  bus_write_n,
    output logic [1:0]  bus_read_n,
    input  logic [31:0] bus_data_in,
    input  logic        bus_data_ready
);

    localparam int                  TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]          STROBE_ON  = 2'b10;
    localparam logic [1:0]          STROBE_OFF = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WAIT,
        S_RD,
        S_RESP
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [31:0]        b_q;
    logic [TIMER_W-1:0] timer;

    // Bus outputs are loaded on entry to a state, so the strobe is on the bus
    // for exactly the cycle the FSM spends in the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= 3'd0;
            b_q          <= 32'd0;
            timer        <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_result   <= 32'd0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            op_count     <= 16'd0;
            bus_address  <= 6'd0;
            bus_data_out <= 32'd0;
            bus_write_n  <= STROBE_OFF;
            bus_read_n   <= STROBE_OFF;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q         <= cmd_op;
                        b_q          <= cmd_b;
                        bus_address  <= {1'b0, cmd_op, 2'b00};
                        bus_data_out <= cmd_a;
                        bus_write_n  <= STROBE_ON;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_WR_A;
                    end
                end
                S_WR_A: begin
                    bus_address  <= {1'b0, op_q, 2'b01};
                    bus_data_out <= b_q;
                    bus_write_n  <= STROBE_ON;
                    state        <= S_WR_B;
                end
                S_WR_B: begin
                    bus_write_n <= STROBE_OFF;
                    timer       <= TIMER_LOAD;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    // Ready wins over the abort on the final permitted WAIT cycle.
                    if (bus_data_ready) begin
                        bus_address <= RESULT_ADDR;
                        bus_read_n  <= STROBE_ON;
                        state       <= S_RD;
                    end else if (timer == '0) begin
                        rsp_err    <= 1'b1;
                        rsp_result <= 32'd0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_RD: begin
                    rsp_result <= bus_data_in;
                    bus_read_n <= STROBE_OFF;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        op_count  <= op_count + 16'd1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    bus_write_n <= STROBE_OFF;
                    bus_read_n  <= STROBE_OFF;
                    rsp_valid   <= 1'b0;
                    cmd_ready   <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tqvp_fpu_bus_initiator.sv
// Bench for tqvp_fpu_bus_initiator: a peripheral model on the bus, a table of directed
// commands, hand-written reset/backpressure sequences and randomized commands.
module tb_tqvp_fpu_bus_initiator;

    localparam int         TO       = 16;
    localparam logic [5:0] RES_ADDR = 6'h0C;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;
    logic [5:0]  bus_address;
    logic [31:0] bus_data_out;
    logic [1:0]  bus_write_n;
    logic [1:0]  bus_read_n;
    logic [31:0] bus_data_in;
    logic        bus_data_ready;

    tqvp_fpu_bus_initiator #(
        .TIMEOUT_CYCLES (TO),
        .RESULT_ADDR    (RES_ADDR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .op_count       (op_count),
        .bus_address    (bus_address),
        .bus_data_out   (bus_data_out),
        .bus_write_n    (bus_write_n),
        .bus_read_n     (bus_read_n),
        .bus_data_in    (bus_data_in),
        .bus_data_ready (bus_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count = 16'd0;

    // Known fp16 results, plus an arbitrary deterministic stand-in for everything else.
    function automatic logic [31:0] fp_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (op == 3'd0 && a[15:0] == 16'h3C00 && b[15:0] == 16'h4000) return 32'h0000_4200;
        if (op == 3'd0 && a[15:0] == 16'h3C00 && b[15:0] == 16'h3C00) return 32'h0000_4000;
        if (op == 3'd1 && a[15:0] == 16'h4200 && b[15:0] == 16'h3C00) return 32'h0000_4000;
        if (op == 3'd2 && a[15:0] == 16'h4000 && b[15:0] == 16'h4200) return 32'h0000_4600;
        return {a[15:0] ^ b[31:16], b[15:0] + a[31:16]} ^ {29'd0, op};
    endfunction

    // Peripheral model: A write clears ready, B write starts a calculation for ops 0-2
    // that raises ready pr_delay cycles later; ops 3-7 never finish.
    typedef struct {
        int          cyc;
        bit          is_read;
        logic [5:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t         ev_log[$];
    int          pr_delay;
    int          pr_cnt;
    logic        pr_ready;
    logic [31:0] pr_a;
    logic [2:0]  pr_op;
    logic [31:0] pr_result;

    assign bus_data_ready = pr_ready;
    assign bus_data_in    = (bus_read_n == 2'b10 && bus_address == RES_ADDR) ? pr_result
                                                                             : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_cnt    <= 0;
            pr_ready  <= 1'b0;
            pr_a      <= 32'd0;
            pr_op     <= 3'd0;
            pr_result <= 32'd0;
        end else begin
            if (pr_cnt > 0) begin
                pr_cnt <= pr_cnt - 1;
                if (pr_cnt == 1) pr_ready <= 1'b1;
            end
            if (bus_write_n == 2'b10) begin
                ev_log.push_back('{cyc, 1'b0, bus_address, bus_data_out});
                if (bus_address[1:0] == 2'b00) begin
                    pr_a     <= bus_data_out;
                    pr_op    <= bus_address[4:2];
                    pr_ready <= 1'b0;
                    pr_cnt   <= 0;
                end else if (bus_address[1:0] == 2'b01) begin
                    pr_result <= fp_calc(pr_op, pr_a, bus_data_out);
                    if (pr_op <= 3'd2) pr_cnt <= pr_delay;
                end
            end
            if (bus_read_n == 2'b10)
                ev_log.push_back('{cyc, 1'b1, bus_address, bus_data_in});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_cmd_ready",    32'(cmd_ready),    32'd1);
        chk("rst_rsp_valid",    32'(rsp_valid),    32'd0);
        chk("rst_rsp_result",   rsp_result,        32'd0);
        chk("rst_rsp_err",      32'(rsp_err),      32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        chk("rst_op_count",     32'(op_count),     32'd0);
        chk("rst_bus_address",  32'(bus_address),  32'd0);
        chk("rst_bus_data_out", bus_data_out,      32'd0);
        chk("rst_bus_write_n",  32'(bus_write_n),  32'd3);
        chk("rst_bus_read_n",   32'(bus_read_n),   32'd3);
    endtask

    // One full command from handshake to response consumption; called at a negedge.
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int d, input int hold, input logic [31:0] e_res,
                           input logic e_err);
        int  n;
        int  t_hs;
        int  base;
        int  e_lat;
        int  ne;
        ev_t exp_ev[3];
        e_lat     = e_err ? 3 + TO : 5 + d;
        pr_delay  = d;
        base      = ev_log.size();
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_bound", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        t_hs = cyc;
        @(negedge clk);
        if (hold > 0) begin
            cmd_op = ~op;
            cmd_a  = ~a;
            cmd_b  = ~b;
        end else begin
            cmd_valid = 1'b0;
        end
        chk("busy_after_hs", 32'(busy), 32'd1);
        chk("cmd_ready_while_busy", 32'(cmd_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            chk("rsp_valid_bound", 32'(rsp_valid), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        chk("latency", 32'(cyc - t_hs), 32'(e_lat));
        chk("rsp_result", rsp_result, e_res);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_result", rsp_result, e_res);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("op_count", 32'(op_count), 32'(exp_count));
        chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        chk("rsp_err_cleared", 32'(rsp_err), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
        ne        = e_err ? 2 : 3;
        exp_ev[0] = '{t_hs + 1, 1'b0, {1'b0, op, 2'b00}, a};
        exp_ev[1] = '{t_hs + 2, 1'b0, {1'b0, op, 2'b01}, b};
        exp_ev[2] = '{t_hs + 4 + d, 1'b1, RES_ADDR, e_res};
        chk("strobe_count", 32'(ev_log.size() - base), 32'(ne));
        for (int i = 0; i < ne && base + i < ev_log.size(); i++) begin
            chk("strobe_cycle", 32'(ev_log[base+i].cyc - t_hs), 32'(exp_ev[i].cyc - t_hs));
            chk("strobe_is_read", 32'(ev_log[base+i].is_read), 32'(exp_ev[i].is_read));
            chk("strobe_addr", 32'(ev_log[base+i].addr), 32'(exp_ev[i].addr));
            chk("strobe_data", ev_log[base+i].data, exp_ev[i].data);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          d;
        int          hold;
        logic [31:0] exp_result;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[9];
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          r_d;
    int          r_hold;
    logic        r_err;
    logic [31:0] r_res;
    int          n_wait;
    int          base_ev;

    initial begin
        vecs[0] = '{3'd0, 32'h0000_3C00, 32'h0000_4000, 3,      0,  32'h0000_4200, 1'b0};
        vecs[1] = '{3'd1, 32'h0000_4200, 32'h0000_3C00, 2,      0,  32'h0000_4000, 1'b0};
        vecs[2] = '{3'd2, 32'h0000_4000, 32'h0000_4200, 1,      0,  32'h0000_4600, 1'b0};
        vecs[3] = '{3'd3, 32'h0000_1234, 32'h0000_5678, 5,      0,  32'h0000_0000, 1'b1};
        vecs[4] = '{3'd0, 32'h0000_3C00, 32'h0000_3C00, TO - 1, 0,  32'h0000_4000, 1'b0};
        vecs[5] = '{3'd0, 32'h0000_3C00, 32'h0000_4000, TO,     0,  32'h0000_0000, 1'b1};
        vecs[6] = '{3'd1, 32'h0000_4200, 32'h0000_3C00, 4,      10, 32'h0000_4000, 1'b0};
        vecs[7] = '{3'd7, 32'hCAFE_0001, 32'hBEEF_0002, 1,      0,  32'h0000_0000, 1'b1};
        vecs[8] = '{3'd2, 32'h0000_4000, 32'h0000_4200, 2,      0,  32'h0000_4600, 1'b0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        pr_delay  = 1;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].hold,
                    vecs[i].exp_result, vecs[i].exp_err);

        // Reset in the middle of WAIT, then a normal command afterwards.
        pr_delay  = 50;
        cmd_op    = 3'd1;
        cmd_a     = 32'h0000_4200;
        cmd_b     = 32'h0000_3C00;
        cmd_valid = 1'b1;
        n_wait    = 0;
        while (!cmd_ready && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        check_reset_values();
        rst_n     = 1'b1;
        exp_count = 16'd0;
        base_ev   = ev_log.size();
        repeat (3) @(negedge clk);
        chk("no_strobe_after_release", 32'(ev_log.size() - base_ev), 32'd0);
        chk("idle_after_release", 32'(busy), 32'd0);
        run_cmd(3'd0, 32'h0000_3C00, 32'h0000_3C00, 2, 0, 32'h0000_4000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            r_op   = 3'($urandom_range(0, 4));
            r_a    = $urandom;
            r_b    = $urandom;
            r_d    = int'($urandom_range(1, TO + 2));
            r_hold = int'($urandom_range(0, 3));
            r_err  = (r_op > 3'd2) || (r_d >= TO);
            r_res  = r_err ? 32'd0 : fp_calc(r_op, r_a, r_b);
            run_cmd(r_op, r_a, r_b, r_d, r_hold, r_res, r_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
